window_3x3_gen: RTL and testbench

- Streaming 3x3 neighbourhood generator for the transmission-estimation stage.
- Accepts one 8-bit pixel per cycle in raster order and buffers two image lines.
- Emits the full 3x3 window centred on each pixel; edge pixels are replicated at image borders.
- Sits directly upstream of the P-block edge-preserving filters; out1..out9 connect to their in1..in9 one-to-one.

---
 rtl/te_pkg.sv | 7 +
 rtl/line_buffer.sv | 24 ++
 rtl/window_3x3_gen.sv | 95 +++++++++
 tb/tb_window_3x3_gen.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
// te_pkg: shared constants and state encoding for the transmission-estimation window stage
package te_pkg;
   localparam int PIX_W     = 8;
   localparam int DEF_IMG_W = 512;
   localparam int DEF_IMG_H = 512;
   typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-deep circular delay line, one read and one write per enabled cycle
module line_buffer #(
   parameter int DEPTH = te_pkg::DEF_IMG_W,
   parameter int PIX_W = te_pkg::PIX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [PIX_W-1:0] i_d,
   output logic [PIX_W-1:0] o_q
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_ptr;
   // the slot about to be overwritten holds the sample from DEPTH advances ago
   assign o_q = r_mem[r_ptr];
   // storage write; contents are don't-care after reset
   always_ff @(posedge clk)
      if (i_en) r_mem[r_ptr] <= i_d;
   // pointer advances once per enabled cycle and wraps at DEPTH
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_ptr <= '0;
      else if (i_en) r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator with replicate padding at borders
module window_3x3_gen
   import te_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = te_pkg::PIX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   output logic             out_last,
   output logic [PIX_W-1:0] out1,
   output logic [PIX_W-1:0] out2,
   output logic [PIX_W-1:0] out3,
   output logic [PIX_W-1:0] out4,
   output logic [PIX_W-1:0] out5,
   output logic [PIX_W-1:0] out6,
   output logic [PIX_W-1:0] out7,
   output logic [PIX_W-1:0] out8,
   output logic [PIX_W-1:0] out9
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int VW = 3 * PIX_W;
   state_t           r_state, w_next;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [VW-1:0]    r_ca, r_cb, w_new, w_l, w_c, w_r;
   logic [PIX_W-1:0] w_lb1, w_lb2;
   logic             w_adv, w_emit, w_done, w_col_end, w_row_end;
   assign in_ready  = (r_state != FLUSH);
   assign w_col_end = (r_col == CW'(IMG_W - 1));
   assign w_row_end = (r_row == RW'(IMG_H - 1));
   // the flush ends on the virtual pixel two rows below the last line, where both counters are back at 0
   assign w_done    = (r_state == FLUSH) && (r_row == '0) && (r_col == '0);
   assign w_adv     = in_ready ? in_valid : !w_done;
   assign w_emit    = (r_state == RUN && in_valid) || r_state == FLUSH;
   line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_d(in_pix), .o_q(w_lb1));
   line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb2 (
      .clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_d(w_lb1), .o_q(w_lb2));
   // incoming column {top, mid, bottom}, row-clamped before it is stored
   assign w_new = {(r_state != FLUSH && r_row == RW'(1)) ? w_lb1 : w_lb2,
                   w_lb1,
                   (r_state == FLUSH) ? w_lb1 : in_pix};
   // column 0 input closes the previous line's last centre, so the right column replicates
   assign w_l = (r_col == CW'(1)) ? r_cb : r_ca;
   assign w_c = r_cb;
   assign w_r = (r_col == '0) ? r_cb : w_new;
   // next-state: fill two lines' worth, stream, then drain the last line without input
   always_comb begin
      w_next = r_state;
      if (r_state == FILL && in_valid && r_row == RW'(1) && r_col == '0) w_next = RUN;
      if (r_state == RUN && in_valid && w_row_end && w_col_end) w_next = FLUSH;
      if (w_done) w_next = FILL;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= FILL;
      else r_state <= w_next;
   // raster counters; the row holds at the last line so the flush can be counted on the column
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_adv) begin
         r_col <= w_col_end ? '0 : r_col + 1'b1;
         if (w_col_end) r_row <= (w_row_end && r_state == RUN) ? r_row : w_row_end ? '0 : r_row + 1'b1;
      end
   // two-column history plus the registered 3x3 window
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_ca      <= '0;
         r_cb      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         {out1, out2, out3, out4, out5, out6, out7, out8, out9} <= '0;
      end else begin
         if (w_adv) begin
            r_ca <= r_cb;
            r_cb <= w_new;
         end
         out_valid <= w_emit;
         out_last  <= w_done;
         if (w_emit) begin
            {out1, out2, out3} <= {w_l[2*PIX_W +: PIX_W], w_c[2*PIX_W +: PIX_W], w_r[2*PIX_W +: PIX_W]};
            {out4, out5, out6} <= {w_l[PIX_W +: PIX_W], w_c[PIX_W +: PIX_W], w_r[PIX_W +: PIX_W]};
            {out7, out8, out9} <= {w_l[0 +: PIX_W], w_c[0 +: PIX_W], w_r[0 +: PIX_W]};
         end
      end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: randomized stream checked against an index-arithmetic window model
module tb_window_3x3_gen;
   localparam int W = 4, H = 3, P = 8, N = W * H;
   typedef logic [9*P-1:0] win_t;
   typedef int iq_t[$];
   logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_last;
   logic [P-1:0] in_pix = '0, out1, out2, out3, out4, out5, out6, out7, out8, out9;
   int n_vec = 0, n_bad = 0;
   int frame[N];
   int mk = 0, mflush = 0, cyc = 0, acc6_cyc = -1, first_v_cyc = -1, first_gap = -1, gap_run = 0;
   logic exp_v = 1'b0, exp_l = 1'b0;
   win_t exp_w = '0, dut_w;
   win_t seen[$];
   logic seen_last[$];
   always #5 clk = ~clk;
   window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
      .out_valid(out_valid), .out_last(out_last),
      .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
      .out6(out6), .out7(out7), .out8(out8), .out9(out9));
   assign dut_w = {out1, out2, out3, out4, out5, out6, out7, out8, out9};
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask
   function automatic int clampi(input int v, input int hi);
      return v < 0 ? 0 : (v > hi ? hi : v);
   endfunction
   function automatic win_t window(input int c);
      win_t w = '0;
      int r = c / W, cc = c % W;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            w = {w[8*P-1:0], P'(frame[clampi(r + dr, H - 1) * W + clampi(cc + dc, W - 1)])};
      return w;
   endfunction
   function automatic iq_t seq(input int base);
      iq_t q;
      for (int i = 0; i < N; i++) q.push_back(base + i);
      return q;
   endfunction
   task automatic stream(input iq_t vals, input int mode);
      int i = 0, n = 0;
      bit t = 1'b1, v;
      while (i < vals.size() && n < 500) begin
         @(posedge clk); #1;
         n++;
         v = (mode == 0) ? 1'b1 : (mode == 1) ? t : ($urandom_range(0, 3) != 0);
         t = !t;
         in_valid = v;
         in_pix = P'(vals[i]);
         if (v && in_ready) i++;
      end
      check("stream_done", i, vals.size());
   endtask
   initial begin
      iq_t rq;
      int pre;
      #1 rst_n = 1'b0;
      fork
         begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            stream(seq(1), 0);
            stream(seq(101), 0);
            stream(seq(1), 1);
            @(posedge clk); #1 in_valid = 1'b0;
            repeat (8) @(posedge clk);
            rq = seq(1);
            rq = rq[0:6];
            stream(rq, 0);
            @(posedge clk); #1 in_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1 check("async_reset", {out_valid, out_last, in_ready, dut_w}, {1'b0, 1'b0, 1'b1, 72'h0});
            @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
            pre = seen.size();
            stream(seq(1), 0);
            repeat (2) begin
               rq = {};
               repeat (N) rq.push_back(int'($urandom_range(0, 255)));
               stream(rq, 2);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            repeat (20) @(posedge clk);
         end
         forever @(negedge clk) begin
            cyc++;
            if (!rst_n) begin
               mk = 0; mflush = 0; exp_w = '0; exp_v = 1'b0; exp_l = 1'b0;
            end
            check("cycle", {out_valid, out_last, in_ready, dut_w}, {exp_v, exp_l, mflush == 0, exp_w});
            if (out_valid) begin
               seen.push_back(dut_w);
               seen_last.push_back(out_last);
               if (first_v_cyc < 0) first_v_cyc = cyc;
            end
            if (!in_ready) gap_run++;
            else begin
               if (gap_run > 0 && first_gap < 0) first_gap = gap_run;
               gap_run = 0;
            end
            exp_v = 1'b0;
            exp_l = 1'b0;
            if (rst_n) begin
               if (mflush == 0 && in_valid) begin
                  frame[mk] = int'(in_pix);
                  if (acc6_cyc < 0 && mk == 5) acc6_cyc = cyc;
                  if (mk >= W + 1) begin
                     exp_v = 1'b1;
                     exp_w = window(mk - W - 1);
                  end
                  mk++;
                  if (mk == N) mflush = W + 1;
               end else if (mflush > 0) begin
                  exp_v = 1'b1;
                  exp_w = window(N - mflush);
                  exp_l = (mflush == 1);
                  mflush--;
                  if (mflush == 0) mk = 0;
               end
            end
         end
      join_any
      disable fork;
      check("window_count", seen.size(), pre + 3 * N);
      check("first_latency", first_v_cyc - acc6_cyc, 1);
      check("first_window", seen[0], {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6});
      check("centre_1_1", seen[5], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      check("final_window", {seen_last[11], seen[11]}, {1'b1, 8'd7, 8'd8, 8'd8, 8'd11, 8'd12, 8'd12, 8'd11, 8'd12, 8'd12});
      check("not_last_early", seen_last[10], 1'b0);
      check("flush_cycles", first_gap, W + 1);
      check("frame2_first", seen[12], {8'd101, 8'd101, 8'd102, 8'd101, 8'd101, 8'd102, 8'd105, 8'd105, 8'd106});
      check("toggle_first", seen[24], {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6});
      check("toggle_centre", seen[29], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      check("restream_first", seen[pre], {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6});
      check("restream_last", {seen_last[pre + 11], seen[pre + 11]}, {1'b1, 8'd7, 8'd8, 8'd8, 8'd11, 8'd12, 8'd12, 8'd11, 8'd12, 8'd12});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
